// File: rtl/alu_pkg.sv
// Shared ALU definitions: nibble width, serial-subtractor state encoding and
// the two's-complement subtract overflow rule.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Overflow when operand signs differ and the result sign differs from the minuend.
  function automatic logic ovf_sub(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub_nibble4.sv
// One 4-bit subtract slice: {c,d} = a + ~b + ~bin, borrow-out is the inverted carry.
module sub_nibble4
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d,
  output logic                bout
);

  logic [NIBBLE_W:0] sum;

  assign sum  = {1'b0, a} + {1'b0, ~b} + {{NIBBLE_W{1'b0}}, ~bin};
  assign d    = sum[NIBBLE_W-1:0];
  assign bout = ~sum[NIBBLE_W];

endmodule

// File: rtl/serial_subtractor4.sv
// Nibble-serial subtractor DIFF = A - B - BI, LSB nibble first, valid/ready on both sides.
// Optional sticky zero flag output Z when SERIAL_SUB_ZERO_FLAG_EN is defined.
module serial_subtractor4
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic             BO,
  output logic             OVF
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             Z
`endif
);

  localparam int NN = WIDTH / NIBBLE_W;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("serial_subtractor4: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  sub_state_t state, nstate;

  logic [WIDTH-1:0]    a_sh, b_sh;
  logic                borrow;
  logic [CW-1:0]       cnt;
  logic                a_msb, b_msb;
  logic [NIBBLE_W-1:0] d;
  logic                bout;
  logic [WIDTH+NIBBLE_W-1:0] diff_cat;
  logic                last;

  sub_nibble4 u_nib (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  assign last      = (cnt == LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff_cat  = {d, DIFF};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (in_valid)  nstate = RUN;
      RUN:     if (last)      nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default:                nstate = IDLE;
    endcase
  end

  // Result nibbles enter at the top so the first (LSB) nibble lands at bit 0 after NN shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      DIFF   <= '0;
      BO     <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_sh   <= A;
          b_sh   <= B;
          borrow <= BI;
          cnt    <= '0;
          a_msb  <= A[WIDTH-1];
          b_msb  <= B[WIDTH-1];
        end
        RUN: begin
          a_sh   <= a_sh >> NIBBLE_W;
          b_sh   <= b_sh >> NIBBLE_W;
          DIFF   <= diff_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
          borrow <= bout;
          if (last) begin
            BO  <= bout;
            OVF <= ovf_sub(a_msb, b_msb, d[NIBBLE_W-1]);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          Z <= 1'b0;
    else if (state == IDLE && in_valid)  Z <= 1'b1;
    else if (state == RUN)               Z <= Z & (d == '0);
  end
`endif

endmodule

// File: tb/tb_serial_subtractor4.sv
// Bench for serial_subtractor4 (WIDTH=16): directed vector table, handshake and
// reset corner cases, and randomized ops against an arithmetic reference.
module tb_serial_subtractor4;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0, B = '0;
  logic         BI = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] DIFF;
  logic         BO, OVF;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic         Z;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .BI(BI),
    .out_valid(out_valid), .out_ready(out_ready),
    .DIFF(DIFF), .BO(BO), .OVF(OVF)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    , .Z(Z)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] diff;
    logic         bo;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for DIFF/BO, signed for OVF.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       output logic [W-1:0] d, output logic bo, output logic ovf);
    int u, s;
    u = int'(a) - int'(b) - int'(bi);
    s = int'($signed(a)) - int'($signed(b)) - int'(bi);
    d   = W'(u);
    bo  = (u < 0);
    ovf = (s > 32767) || (s < -32768);
  endtask

  // Issue one op, check in_ready low during RUN and the exact latency, then result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W-1:0] ed, input logic ebo, input logic eovf,
                        input int hold);
    int lat;
    int t;
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    chk("in_ready_before_op", {31'b0, in_ready}, 32'd1);
    A = a; B = b; BI = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; BI = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("in_ready_run", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, W / 4);
    chk("diff", {16'b0, DIFF}, {16'b0, ed});
    chk("bo", {31'b0, BO}, {31'b0, ebo});
    chk("ovf", {31'b0, OVF}, {31'b0, eovf});
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    chk("z", {31'b0, Z}, {31'b0, (ed == '0)});
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_diff", {16'b0, DIFF}, {16'b0, ed});
      chk("hold_flags", {30'b0, BO, OVF}, {30'b0, ebo, eovf});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", {31'b0, out_valid}, 32'd0);
    chk("release_ready", {31'b0, in_ready}, 32'd1);
  endtask

  vec_t vt[5];

  initial begin
    logic [W-1:0] md;
    logic mbo, movf;
    logic [W-1:0] ra, rb;
    logic rbi;

    vt[0] = '{a:16'h1234, b:16'h0234, bi:1'b0, diff:16'h1000, bo:1'b0, ovf:1'b0};
    vt[1] = '{a:16'h0000, b:16'h0001, bi:1'b0, diff:16'hFFFF, bo:1'b1, ovf:1'b0};
    vt[2] = '{a:16'h8000, b:16'h0001, bi:1'b0, diff:16'h7FFF, bo:1'b0, ovf:1'b1};
    vt[3] = '{a:16'h7FFF, b:16'hFFFF, bi:1'b0, diff:16'h8000, bo:1'b1, ovf:1'b1};
    vt[4] = '{a:16'h0005, b:16'h0003, bi:1'b1, diff:16'h0001, bo:1'b0, ovf:1'b0};

    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_diff", {16'b0, DIFF}, 32'd0);
    chk("rst_flags", {30'b0, BO, OVF}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_op(vt[i].a, vt[i].b, vt[i].bi, vt[i].diff, vt[i].bo, vt[i].ovf, 0);

    // Zero-flag cases (Z is checked inside run_op when the feature is built in).
    run_op(16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
    run_op(16'h5A5B, 16'h5A5A, 1'b0, 16'h0001, 1'b0, 1'b0, 0);

    // Backpressure: three cycles with out_ready low and in_valid toggling.
    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 3);

    // Reset during the second RUN cycle discards the op.
    A = 16'hFFFF; B = 16'h0001; BI = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_diff", {16'b0, DIFF}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rbi, md, mbo, movf);
      run_op(ra, rb, rbi, md, mbo, movf, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor4.md
Name: serial_subtractor4

Overview:
- Multi-cycle subtractor: computes DIFF = A - B - BI over WIDTH-bit operands, one 4-bit nibble per clock, LSB nibble first.
- The ripple borrow passes between cycles through a one-bit borrow register.
- It is the subtract-direction counterpart of the 4-bit ripple adder. The ALU datapath uses it where area matters more than latency.
- Valid/ready handshake on both the input side and the output side.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  A, B and BI are valid.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- BI  input  1  borrow-in.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- DIFF  output  WIDTH  A - B - BI modulo 2^WIDTH.
- BO  output  1  borrow-out (1 when A < B + BI, unsigned).
- OVF  output  1  two's-complement overflow.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values (async on rst_n low): state=IDLE, in_ready=1, out_valid=0, DIFF=0, BO=0, OVF=0, nibble counter=0, borrow register=0. Any in-flight operation is discarded; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge:
    - latch A and B into shift registers;
    - borrow register <= BI;
    - counter <= 0;
    - go to RUN.
  - RUN: in_ready=0. Each edge computes one nibble as {c,d} = a_nib + ~b_nib + ~borrow, where c is the carry-out of that 4-bit sum:
    - d shifts into the DIFF register from the top;
    - borrow <= ~c;
    - counter increments.
    - On the edge that processes nibble WIDTH/4-1:
      - BO <= ~c;
      - OVF <= (A[MSB]!=B[MSB]) && (d[3]!=A[MSB]), using the latched A;
      - go to DONE.
  - DONE: out_valid=1; DIFF, BO and OVF are held stable. On out_valid&&out_ready, go to IDLE.
- Latency: out_valid rises exactly WIDTH/4 edges after the accept edge (4 for WIDTH=16).
- Throughput: one operation per WIDTH/4+2 cycles. There is no same-cycle accept in DONE, because in_ready=0 there.
- Backpressure: if out_ready stays low, the block holds DONE indefinitely with outputs unchanged.
- A, B and BI may change freely after the accept edge; they are ignored outside IDLE.
- in_valid while not in_ready: ignored, no state change.
- Counter width is clog2(WIDTH/4), minimum 1 bit. It is compared against WIDTH/4-1 and never wraps past it.
- Outputs are registered; no combinational path from in_valid/out_ready to in_ready/out_valid.

Optional Feature:
- Macro SERIAL_SUB_ZERO_FLAG_EN.
- Defined: extra output port Z (1 bit), reset 0.
  - Z is a sticky "all nibbles zero" register: set to 1 at accept, then ANDed with (d==0) each RUN edge.
  - Valid with out_valid, held in DONE.
- Undefined: port Z and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - NIBBLE_W=4;
  - state typedef sub_state_t {IDLE, RUN, DONE};
  - function ovf_sub(a_msb, b_msb, d_msb).
- Sub-module sub_nibble4 (combinational): inputs a[3:0], b[3:0], bin; outputs d[3:0], bout. Implements a + ~b + ~bin. Instantiated once in RUN datapath.

Test Plan:
- A=0x1234, B=0x0234, BI=0 -> after 4 cycles DIFF=0x1000, BO=0, OVF=0; in_ready low during RUN.
- A=0x0000, B=0x0001, BI=0 -> DIFF=0xFFFF, BO=1, OVF=0 (borrow ripples through all four nibble cycles).
- A=0x8000, B=0x0001 -> DIFF=0x7FFF, BO=0, OVF=1. Then A=0x7FFF, B=0xFFFF -> DIFF=0x8000, BO=1, OVF=1.
- A=0x0005, B=0x0003, BI=1 -> DIFF=0x0001, BO=0. With SERIAL_SUB_ZERO_FLAG_EN: A=B=0x5A5A -> Z=1; A=0x5A5B, B=0x5A5A -> Z=0.
- out_ready held low 3 cycles in DONE -> out_valid, DIFF, BO and OVF stable; in_valid pulses ignored. out_ready=1 -> IDLE next edge, in_ready=1.
- rst_n asserted in the 2nd RUN cycle of A=0xFFFF, B=0x0001 -> immediately out_valid=0, in_ready=1, DIFF=0. A fresh op after release yields the correct result.
